load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_LIMIT, default 4096, meaning the byte-address bound of the data memory (addresses >= ADDR_LIMIT fault).
REQ-002 i_clk  in  1  single clock; all state updates on its rising edge.
REQ-003 i_reset  in  1  synchronous, active-high reset.
REQ-004 i_req_valid  in  1  upstream request valid.
REQ-005 o_req_ready  out  1  unit can accept a request.
REQ-006 i_req_op  in  4  op: 0 LB, 1 LH, 2 LW, 3 LBU, 4 LHU, 5 SB, 6 SH, 7 SW, 8-15 illegal.
REQ-007 i_req_addr  in  32  byte address.
REQ-008 i_req_wdata  in  32  store data, low bits used for SB/SH.
REQ-009 i_req_rd  in  5  destination register tag.
REQ-010 o_rsp_valid  out  1  response valid.
REQ-011 i_rsp_ready  in  1  downstream accepts response.
REQ-012 o_rsp_data  out  32  load data; 0 for stores and faults.
REQ-013 o_rsp_rd  out  5  tag of the request; 0 for stores.
REQ-014 o_rsp_err  out  2  0 none, 1 misaligned, 2 out of range, 3 illegal op.
REQ-015 o_mem_address, o_mem_wr_data  out  32 each; o_mem_wr_mask  out  2; o_mem_rd_mask  out  3 -- data memory port.
REQ-016 i_mem_rd_data  in  32  registered memory read data, valid one edge after the read mask is applied.

Function
REQ-017 SHALL implement FSM IDLE, LOAD_WAIT, RESP; o_req_ready = 1 only in IDLE with i_reset low.
REQ-018 Accept = i_req_valid & o_req_ready; at most one request outstanding.
REQ-019 Errors SHALL be checked combinationally at accept, priority illegal > misaligned > out of range; misaligned = LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0; out of range = addr >= ADDR_LIMIT.
REQ-020 During the accept cycle only, a valid error-free request SHALL drive o_mem_address=i_req_addr and o_mem_wr_data=i_req_wdata, with masks: LB->BE(4), LH->HE(3), LW->W(0), LBU->BZ(2), LHU->HZ(1), SB->wr B(1), SH->wr H(2), SW->wr W(3).
REQ-021 Every other cycle, including faulted accepts and reset, SHALL drive o_mem_wr_mask=N(0) and o_mem_rd_mask=XX(5).
REQ-022 Store or faulted accept at cycle N: IDLE->RESP, o_rsp_valid high from cycle N+1; the store write commits at the edge ending cycle N.
REQ-023 Load accept at cycle N: IDLE->LOAD_WAIT; in N+1 capture i_mem_rd_data into the response register; RESP with o_rsp_valid high from N+2.
REQ-024 In RESP, o_rsp_* SHALL hold stable until i_rsp_ready; on handshake go to IDLE (new accept no earlier than next cycle).
REQ-025 Faulted responses SHALL carry o_rsp_data=0, o_rsp_rd=i_req_rd, and make no memory access.
REQ-026 Sign/zero extension SHALL be done by the memory; the unit SHALL pass captured data unmodified.

Reset
REQ-027 On i_reset: state IDLE, o_rsp_valid=0, o_rsp_data=0, o_rsp_rd=0, o_rsp_err=0; outstanding request dropped.
REQ-028 Reset in the same cycle as i_req_valid SHALL accept nothing and issue no write.
REQ-029 Reset in LOAD_WAIT or RESP SHALL discard the pending response.

Structure
REQ-030 Shared package argon_pkg SHALL hold WRMASK_*, RDMASK_* constants, lsu_op_t enum, and lsu_err_t codes; the memory block imports the same constants.
REQ-031 One combinational sub-module lsu_decode (op+addr -> masks, error code) SHALL be used; FSM and response register stay in load_store_unit.

Verification
REQ-032 SW addr 0x10 data 0xDEADBEEF, then LW 0x10 rd=5 -> store response at N+1 with err=0, rd=0; load response at N+2 with data 0xDEADBEEF, rd=5.
REQ-033 After REQ-032, LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LHU 0x12 -> 0x0000DEAD; LH 0x10 -> 0xFFFFBEEF.
REQ-034 LW 0x11 and SH 0x21 -> err=1, data 0, wr/rd masks stay N/XX every cycle, memory unchanged.
REQ-035 LW 0x1000 -> err=2; op 9 at addr 0x3 -> err=3 (illegal beats misaligned).
REQ-036 Load response with i_rsp_ready low for 3 cycles -> o_rsp_* stable, o_req_ready 0; accept on cycle after handshake.
REQ-037 Reset asserted in LOAD_WAIT -> o_rsp_valid 0 next cycle, IDLE, no late response; reset concurrent with SB valid -> memory unchanged.

Source files
------------

// File: rtl/argon_pkg.sv
// Shared load/store types and memory-port mask encodings.
// The data memory model uses the same constants.
package argon_pkg;

  localparam logic [1:0] WRMASK_N = 2'd0;
  localparam logic [1:0] WRMASK_B = 2'd1;
  localparam logic [1:0] WRMASK_H = 2'd2;
  localparam logic [1:0] WRMASK_W = 2'd3;

  localparam logic [2:0] RDMASK_W  = 3'd0;
  localparam logic [2:0] RDMASK_HZ = 3'd1;
  localparam logic [2:0] RDMASK_BZ = 3'd2;
  localparam logic [2:0] RDMASK_HE = 3'd3;
  localparam logic [2:0] RDMASK_BE = 3'd4;
  localparam logic [2:0] RDMASK_XX = 3'd5;

  typedef enum logic [3:0] {
    OP_LB  = 4'd0,
    OP_LH  = 4'd1,
    OP_LW  = 4'd2,
    OP_LBU = 4'd3,
    OP_LHU = 4'd4,
    OP_SB  = 4'd5,
    OP_SH  = 4'd6,
    OP_SW  = 4'd7
  } lsu_op_t;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_ALIGN = 2'd1,
    ERR_RANGE = 2'd2,
    ERR_OP    = 2'd3
  } lsu_err_t;

endpackage

// File: rtl/lsu_decode.sv
// Op/address decode: memory masks and fault code.
// Pure combinational, evaluated in the accept cycle.
module lsu_decode
  import argon_pkg::*;
#(
  parameter int unsigned ADDR_LIMIT = 4096
) (
  input  logic [3:0]  op,
  input  logic [31:0] addr,
  output logic        is_load,
  output logic [1:0]  wr_mask,
  output logic [2:0]  rd_mask,
  output lsu_err_t    err
);

  logic illegal;
  logic mis;
  logic oor;

  assign oor = (addr >= ADDR_LIMIT);

  // Op decode into masks and alignment requirement
  always_comb begin
    is_load = 1'b0;
    wr_mask = WRMASK_N;
    rd_mask = RDMASK_XX;
    illegal = 1'b0;
    mis     = 1'b0;
    unique case (op)
      OP_LB:  begin is_load = 1'b1; rd_mask = RDMASK_BE; end
      OP_LH:  begin is_load = 1'b1; rd_mask = RDMASK_HE; mis = addr[0]; end
      OP_LW:  begin is_load = 1'b1; rd_mask = RDMASK_W;  mis = |addr[1:0]; end
      OP_LBU: begin is_load = 1'b1; rd_mask = RDMASK_BZ; end
      OP_LHU: begin is_load = 1'b1; rd_mask = RDMASK_HZ; mis = addr[0]; end
      OP_SB:  wr_mask = WRMASK_B;
      OP_SH:  begin wr_mask = WRMASK_H; mis = addr[0]; end
      OP_SW:  begin wr_mask = WRMASK_W; mis = |addr[1:0]; end
      default: illegal = 1'b1;
    endcase
  end

  // Fault priority: illegal, then misaligned, then range
  always_comb begin
    err = ERR_NONE;
    unique case (1'b1)
      illegal:               err = ERR_OP;
      !illegal && mis:       err = ERR_ALIGN;
      !illegal && !mis && oor: err = ERR_RANGE;
      default:               err = ERR_NONE;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit with registered response.
// Memory does extension; captured read data passes through as is.
module load_store_unit
  import argon_pkg::*;
#(
  parameter int unsigned ADDR_LIMIT = 4096
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [3:0]  i_req_op,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  input  logic [4:0]  i_req_rd,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_data,
  output logic [4:0]  o_rsp_rd,
  output logic [1:0]  o_rsp_err,
  output logic [31:0] o_mem_address,
  output logic [31:0] o_mem_wr_data,
  output logic [1:0]  o_mem_wr_mask,
  output logic [2:0]  o_mem_rd_mask,
  input  logic [31:0] i_mem_rd_data
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_WAIT = 2'd1,
    RESP      = 2'd2
  } state_t;

  state_t   state;
  state_t   state_n;
  logic     is_load;
  logic [1:0] dec_wr;
  logic [2:0] dec_rd;
  lsu_err_t dec_err;
  logic     accept;
  logic     ok;

  logic [31:0] rsp_data;
  logic [4:0]  rsp_rd;
  lsu_err_t    rsp_err;

  lsu_decode #(
    .ADDR_LIMIT(ADDR_LIMIT)
  ) u_dec (
    .op     (i_req_op),
    .addr   (i_req_addr),
    .is_load(is_load),
    .wr_mask(dec_wr),
    .rd_mask(dec_rd),
    .err    (dec_err)
  );

  assign o_req_ready = (state == IDLE) && !i_reset;
  assign accept      = i_req_valid && o_req_ready;
  assign ok          = (dec_err == ERR_NONE);
  assign o_rsp_valid = (state == RESP);
  assign o_rsp_data  = rsp_data;
  assign o_rsp_rd    = rsp_rd;
  assign o_rsp_err   = rsp_err;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) state <= IDLE;
    else         state <= state_n;
  end

  // Next state: loads wait one cycle for memory data
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (accept)
          state_n = (is_load && ok) ? LOAD_WAIT : RESP;
      end
      LOAD_WAIT: state_n = RESP;
      RESP: begin
        if (i_rsp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Memory port is active only in an error-free accept cycle
  always_comb begin
    o_mem_address = 32'd0;
    o_mem_wr_data = 32'd0;
    o_mem_wr_mask = WRMASK_N;
    o_mem_rd_mask = RDMASK_XX;
    if (accept && ok) begin
      o_mem_address = i_req_addr;
      o_mem_wr_data = i_req_wdata;
      o_mem_wr_mask = dec_wr;
      o_mem_rd_mask = dec_rd;
    end
  end

  // Response register: set at accept, load data filled in LOAD_WAIT
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rsp_data <= 32'd0;
      rsp_rd   <= 5'd0;
      rsp_err  <= ERR_NONE;
    end else if (accept) begin
      rsp_data <= 32'd0;
      rsp_err  <= dec_err;
      rsp_rd   <= (ok && !is_load) ? 5'd0 : i_req_rd;
    end else if (state == LOAD_WAIT) begin
      rsp_data <= i_mem_rd_data;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a byte-wide memory model.
// Memory applies masks and does sign/zero extension.
module tb_load_store_unit;
  import argon_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_req_valid;
  logic        o_req_ready;
  logic [3:0]  i_req_op;
  logic [31:0] i_req_addr;
  logic [31:0] i_req_wdata;
  logic [4:0]  i_req_rd;
  logic        o_rsp_valid;
  logic        i_rsp_ready;
  logic [31:0] o_rsp_data;
  logic [4:0]  o_rsp_rd;
  logic [1:0]  o_rsp_err;
  logic [31:0] o_mem_address;
  logic [31:0] o_mem_wr_data;
  logic [1:0]  o_mem_wr_mask;
  logic [2:0]  o_mem_rd_mask;
  logic [31:0] i_mem_rd_data;

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  load_store_unit #(.ADDR_LIMIT(4096)) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_req_valid  (i_req_valid),
    .o_req_ready  (o_req_ready),
    .i_req_op     (i_req_op),
    .i_req_addr   (i_req_addr),
    .i_req_wdata  (i_req_wdata),
    .i_req_rd     (i_req_rd),
    .o_rsp_valid  (o_rsp_valid),
    .i_rsp_ready  (i_rsp_ready),
    .o_rsp_data   (o_rsp_data),
    .o_rsp_rd     (o_rsp_rd),
    .o_rsp_err    (o_rsp_err),
    .o_mem_address(o_mem_address),
    .o_mem_wr_data(o_mem_wr_data),
    .o_mem_wr_mask(o_mem_wr_mask),
    .o_mem_rd_mask(o_mem_rd_mask),
    .i_mem_rd_data(i_mem_rd_data)
  );

  // Data memory model, little-endian bytes
  logic [7:0]  mem [0:4095];
  logic [11:0] ma;
  logic [7:0]  b0, b1, b2, b3;
  assign ma = o_mem_address[11:0];
  assign b0 = mem[ma];
  assign b1 = mem[ma + 12'd1];
  assign b2 = mem[ma + 12'd2];
  assign b3 = mem[ma + 12'd3];

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    i_mem_rd_data = 32'd0;
  end

  always @(posedge i_clk) begin
    case (o_mem_wr_mask)
      WRMASK_B: mem[ma] <= o_mem_wr_data[7:0];
      WRMASK_H: begin
        mem[ma]         <= o_mem_wr_data[7:0];
        mem[ma + 12'd1] <= o_mem_wr_data[15:8];
      end
      WRMASK_W: begin
        mem[ma]         <= o_mem_wr_data[7:0];
        mem[ma + 12'd1] <= o_mem_wr_data[15:8];
        mem[ma + 12'd2] <= o_mem_wr_data[23:16];
        mem[ma + 12'd3] <= o_mem_wr_data[31:24];
      end
      default: ;
    endcase
    case (o_mem_rd_mask)
      RDMASK_W:  i_mem_rd_data <= {b3, b2, b1, b0};
      RDMASK_HZ: i_mem_rd_data <= {16'h0, b1, b0};
      RDMASK_BZ: i_mem_rd_data <= {24'h0, b0};
      RDMASK_HE: i_mem_rd_data <= {{16{b1[7]}}, b1, b0};
      RDMASK_BE: i_mem_rd_data <= {{24{b0[7]}}, b0};
      default: ;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [31:0] edata;
    logic [4:0]  erd;
    logic [1:0]  eerr;
    int          elat;
    logic [1:0]  ewm;
    logic [2:0]  erm;
  } vec_t;

  vec_t vt [17];

  task automatic run_vec(input vec_t v, input int idx);
    int  lat;
    bit  idle_ok;
    string tag;
    tag = $sformatf("v%0d", idx);
    @(negedge i_clk);
    i_req_valid = 1'b1;
    i_req_op    = v.op;
    i_req_addr  = v.addr;
    i_req_wdata = v.wdata;
    i_req_rd    = v.rd;
    #1;
    chk({tag, " ready"}, 32'(o_req_ready), 32'd1);
    chk({tag, " wmask"}, 32'(o_mem_wr_mask), 32'(v.ewm));
    chk({tag, " rmask"}, 32'(o_mem_rd_mask), 32'(v.erm));
    if (v.ewm != WRMASK_N || v.erm != RDMASK_XX)
      chk({tag, " maddr"}, o_mem_address, v.addr);
    @(negedge i_clk);
    i_req_valid = 1'b0;
    lat = 1;
    idle_ok = 1'b1;
    while (!o_rsp_valid && lat < 8) begin
      if (o_mem_wr_mask != WRMASK_N || o_mem_rd_mask != RDMASK_XX)
        idle_ok = 1'b0;
      @(negedge i_clk);
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'(v.elat));
    chk({tag, " data"}, o_rsp_data, v.edata);
    chk({tag, " rd"}, 32'(o_rsp_rd), 32'(v.erd));
    chk({tag, " err"}, 32'(o_rsp_err), 32'(v.eerr));
    chk({tag, " idle masks"}, 32'(idle_ok), 32'd1);
    i_rsp_ready = 1'b1;
    @(negedge i_clk);
    i_rsp_ready = 1'b0;
    chk({tag, " rsp dropped"}, 32'(o_rsp_valid), 32'd0);
    chk({tag, " ready again"}, 32'(o_req_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d0;
    logic [4:0]  r0;
    logic [1:0]  e0;
    int          n;

    vt[0]  = '{OP_SW,  32'h10,   32'hDEADBEEF, 5'd3,  32'h0,        5'd0,  2'd0, 1, WRMASK_W, RDMASK_XX};
    vt[1]  = '{OP_LW,  32'h10,   32'h0,        5'd5,  32'hDEADBEEF, 5'd5,  2'd0, 2, WRMASK_N, RDMASK_W};
    vt[2]  = '{OP_LB,  32'h13,   32'h0,        5'd1,  32'hFFFFFFDE, 5'd1,  2'd0, 2, WRMASK_N, RDMASK_BE};
    vt[3]  = '{OP_LBU, 32'h13,   32'h0,        5'd2,  32'h000000DE, 5'd2,  2'd0, 2, WRMASK_N, RDMASK_BZ};
    vt[4]  = '{OP_LHU, 32'h12,   32'h0,        5'd3,  32'h0000DEAD, 5'd3,  2'd0, 2, WRMASK_N, RDMASK_HZ};
    vt[5]  = '{OP_LH,  32'h10,   32'h0,        5'd4,  32'hFFFFBEEF, 5'd4,  2'd0, 2, WRMASK_N, RDMASK_HE};
    vt[6]  = '{OP_LW,  32'h11,   32'h0,        5'd7,  32'h0,        5'd7,  2'd1, 1, WRMASK_N, RDMASK_XX};
    vt[7]  = '{OP_SH,  32'h21,   32'hFFFF,     5'd8,  32'h0,        5'd8,  2'd1, 1, WRMASK_N, RDMASK_XX};
    vt[8]  = '{OP_LW,  32'h1000, 32'h0,        5'd9,  32'h0,        5'd9,  2'd2, 1, WRMASK_N, RDMASK_XX};
    vt[9]  = '{4'd9,   32'h3,    32'h0,        5'd10, 32'h0,        5'd10, 2'd3, 1, WRMASK_N, RDMASK_XX};
    vt[10] = '{OP_SB,  32'h20,   32'h11223355, 5'd11, 32'h0,        5'd0,  2'd0, 1, WRMASK_B, RDMASK_XX};
    vt[11] = '{OP_SH,  32'h22,   32'hABCD1234, 5'd12, 32'h0,        5'd0,  2'd0, 1, WRMASK_H, RDMASK_XX};
    vt[12] = '{OP_LW,  32'h20,   32'h0,        5'd13, 32'h12340055, 5'd13, 2'd0, 2, WRMASK_N, RDMASK_W};
    vt[13] = '{OP_LW,  32'h10,   32'h0,        5'd14, 32'hDEADBEEF, 5'd14, 2'd0, 2, WRMASK_N, RDMASK_W};
    vt[14] = '{OP_LW,  32'hFFC,  32'h0,        5'd15, 32'h0,        5'd15, 2'd0, 2, WRMASK_N, RDMASK_W};
    vt[15] = '{OP_SW,  32'h1000, 32'h5,        5'd16, 32'h0,        5'd16, 2'd2, 1, WRMASK_N, RDMASK_XX};
    vt[16] = '{4'd15,  32'h0,    32'h0,        5'd17, 32'h0,        5'd17, 2'd3, 1, WRMASK_N, RDMASK_XX};

    i_reset     = 1'b1;
    i_req_valid = 1'b0;
    i_req_op    = 4'd0;
    i_req_addr  = 32'd0;
    i_req_wdata = 32'd0;
    i_req_rd    = 5'd0;
    i_rsp_ready = 1'b0;
    repeat (2) @(negedge i_clk);
    chk("rst valid", 32'(o_rsp_valid), 32'd0);
    chk("rst data", o_rsp_data, 32'd0);
    chk("rst rd", 32'(o_rsp_rd), 32'd0);
    chk("rst err", 32'(o_rsp_err), 32'd0);
    chk("rst ready", 32'(o_req_ready), 32'd0);
    chk("rst wmask", 32'(o_mem_wr_mask), 32'(WRMASK_N));
    chk("rst rmask", 32'(o_mem_rd_mask), 32'(RDMASK_XX));
    i_reset = 1'b0;
    @(negedge i_clk);
    chk("post rst ready", 32'(o_req_ready), 32'd1);

    for (int i = 0; i < 17; i++) run_vec(vt[i], i);

    // Response stall: outputs hold while downstream is not ready
    @(negedge i_clk);
    i_req_valid = 1'b1;
    i_req_op    = OP_LW;
    i_req_addr  = 32'h10;
    i_req_rd    = 5'd5;
    @(negedge i_clk);
    i_req_valid = 1'b0;
    n = 0;
    while (!o_rsp_valid && n < 8) begin
      @(negedge i_clk);
      n++;
    end
    chk("stall rsp valid", 32'(o_rsp_valid), 32'd1);
    d0 = o_rsp_data;
    r0 = o_rsp_rd;
    e0 = o_rsp_err;
    chk("stall data", d0, 32'hDEADBEEF);
    for (int k = 0; k < 3; k++) begin
      i_req_valid = 1'b1;
      i_req_op    = OP_SB;
      i_req_addr  = 32'h40;
      i_req_wdata = 32'h77;
      #1;
      chk("stall no ready", 32'(o_req_ready), 32'd0);
      chk("stall no write", 32'(o_mem_wr_mask), 32'(WRMASK_N));
      @(negedge i_clk);
      chk("stall valid", 32'(o_rsp_valid), 32'd1);
      chk("stall hold data", o_rsp_data, d0);
      chk("stall hold rd", 32'(o_rsp_rd), 32'(r0));
      chk("stall hold err", 32'(o_rsp_err), 32'(e0));
    end
    i_req_valid = 1'b0;
    i_rsp_ready = 1'b1;
    @(negedge i_clk);
    i_rsp_ready = 1'b0;
    chk("stall handshake", 32'(o_rsp_valid), 32'd0);
    chk("stall ready after", 32'(o_req_ready), 32'd1);
    run_vec('{OP_LBU, 32'h40, 32'h0, 5'd6, 32'h0, 5'd6, 2'd0, 2,
              WRMASK_N, RDMASK_BZ}, 100);

    // Reset during LOAD_WAIT drops the pending load
    @(negedge i_clk);
    i_req_valid = 1'b1;
    i_req_op    = OP_LW;
    i_req_addr  = 32'h10;
    i_req_rd    = 5'd9;
    @(negedge i_clk);
    i_req_valid = 1'b0;
    chk("lw in wait", 32'(o_rsp_valid), 32'd0);
    i_reset = 1'b1;
    @(negedge i_clk);
    chk("rstw valid", 32'(o_rsp_valid), 32'd0);
    chk("rstw data", o_rsp_data, 32'd0);
    chk("rstw rd", 32'(o_rsp_rd), 32'd0);
    i_reset = 1'b0;
    @(negedge i_clk);
    chk("rstw ready", 32'(o_req_ready), 32'd1);
    n = 0;
    for (int k = 0; k < 4; k++) begin
      if (o_rsp_valid) n++;
      @(negedge i_clk);
    end
    chk("rstw no late rsp", 32'(n), 32'd0);

    // Reset concurrent with a store request: nothing written
    i_reset     = 1'b1;
    i_req_valid = 1'b1;
    i_req_op    = OP_SB;
    i_req_addr  = 32'h30;
    i_req_wdata = 32'hAA;
    i_req_rd    = 5'd1;
    #1;
    chk("rsts ready", 32'(o_req_ready), 32'd0);
    chk("rsts wmask", 32'(o_mem_wr_mask), 32'(WRMASK_N));
    @(negedge i_clk);
    i_reset     = 1'b0;
    i_req_valid = 1'b0;
    chk("rsts no rsp", 32'(o_rsp_valid), 32'd0);
    run_vec('{OP_LBU, 32'h30, 32'h0, 5'd2, 32'h0, 5'd2, 2'd0, 2,
              WRMASK_N, RDMASK_BZ}, 101);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
